// File: rtl/gfg_spi_slave_burst.sv
// SPI target with burst read/write access to a register file, all four SPI modes,
// SPI pins oversampled and edge-detected in the system clock domain.
`timescale 1ns/1ps
module gfg_spi_slave_burst #(
  parameter int NUM_REGISTERS  = 32,
  parameter int REGISTER_WIDTH = 32,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0,
  parameter int SYNC_STAGES    = 2,
  localparam int ADDR_W = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1,
  localparam int FW     = 8 * ((REGISTER_WIDTH + 7) / 8)
) (
  input  logic                      i_sys_clk,
  input  logic                      i_arst_n,
  input  logic                      i_spi_clk,
  input  logic                      i_spi_mosi,
  input  logic                      i_spi_ss_n,
  output logic                      o_spi_miso,
  output logic [ADDR_W-1:0]         o_reg_addr,
  output logic [REGISTER_WIDTH-1:0] o_reg_write_data,
  output logic                      o_reg_write_en,
  input  logic [REGISTER_WIDTH-1:0] i_reg_read_data,
  output logic                      o_abort,
  output logic [4:0]                o_state
);

  localparam int   CNT_W    = $clog2(FW);
  localparam logic IDLE_LVL = 1'(CPOL);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_CMD   = 5'b00010;
  localparam logic [4:0] S_LOAD  = 5'b00100;
  localparam logic [4:0] S_XFER  = 5'b01000;
  localparam logic [4:0] S_STORE = 5'b10000;

  // Reset asserts immediately, releases synchronously to i_sys_clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ss_n synchroniser resets low so a select already active at reset release never arms us.
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_prev_q;
  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= IDLE_LVL;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], i_spi_ss_n};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, mosi_s, ss_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign lead_edge   = (sclk_s != IDLE_LVL) && (sclk_prev_q == IDLE_LVL);
  assign trail_edge  = (sclk_s == IDLE_LVL) && (sclk_prev_q != IDLE_LVL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  logic [4:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]             rx_q, rx_d, tx_q, tx_d, rx_next;
  logic [ADDR_W-1:0]         addr_q, addr_d, addr_inc;
  logic                      ai_q, ai_d, rd_q, rd_d, load_wait_q, load_wait_d;
  logic                      miso_q, miso_d, we_q, we_d, abort_q, abort_d, armed_q, armed_d;
  logic [REGISTER_WIDTH-1:0] wdata_q, wdata_d;

  assign rx_next  = {rx_q[FW-2:0], mosi_s};
  assign addr_inc = !ai_q ? addr_q :
                    (addr_q == ADDR_W'(NUM_REGISTERS - 1)) ? '0 : addr_q + ADDR_W'(1);

  // Register port has no handshake: o_reg_addr is registered, i_reg_read_data is taken
  // one cycle after it changes, and o_reg_write_en is a single-cycle strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    ai_d        = ai_q;
    rd_d        = rd_q;
    load_wait_d = 1'b0;
    miso_d      = miso_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    abort_d     = 1'b0;
    armed_d     = armed_q | ss_s;
    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (armed_q && !ss_s) state_d = S_CMD;
      end
      S_CMD: begin
        miso_d = 1'b0;
        if (ss_s) begin
          state_d = S_IDLE;
          abort_d = (cnt_q != '0);
        end else if (sample_edge) begin
          rx_d = rx_next;
          if (cnt_q == CNT_W'(7)) begin
            cnt_d  = '0;
            addr_d = rx_next[ADDR_W-1:0];
            ai_d   = rx_next[5];
            case (rx_next[7:6])
              2'b01:   begin rd_d = 1'b1; state_d = S_LOAD; end
              2'b10:   begin rd_d = 1'b0; state_d = S_XFER; end
              default: begin addr_d = addr_q; ai_d = ai_q; state_d = S_IDLE; end
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LOAD: begin
        load_wait_d = ~load_wait_q;
        if (load_wait_q) begin
          tx_d    = FW'(i_reg_read_data) << (FW - REGISTER_WIDTH);
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (ss_s) begin
          state_d = S_IDLE;
          abort_d = (cnt_q != '0);
          miso_d  = 1'b0;
        end else begin
          if (shift_edge && rd_q) begin
            miso_d = tx_q[FW-1];
            tx_d   = tx_q << 1;
          end
          if (sample_edge) begin
            rx_d = rx_next;
            if (cnt_q == CNT_W'(FW - 1)) begin
              cnt_d = '0;
              if (rd_q) begin
                addr_d  = addr_inc;
                state_d = S_LOAD;
              end else begin
                wdata_d = rx_next[FW-1 -: REGISTER_WIDTH];
                we_d    = 1'b1;
                state_d = S_STORE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      S_STORE: begin
        addr_d  = addr_inc;
        state_d = S_XFER;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      ai_q        <= 1'b0;
      rd_q        <= 1'b0;
      load_wait_q <= 1'b0;
      miso_q      <= 1'b0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      abort_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      ai_q        <= ai_d;
      rd_q        <= rd_d;
      load_wait_q <= load_wait_d;
      miso_q      <= miso_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      abort_q     <= abort_d;
      armed_q     <= armed_d;
    end
  end

  assign o_spi_miso       = miso_q;
  assign o_reg_addr       = addr_q;
  assign o_reg_write_data = wdata_q;
  assign o_reg_write_en   = we_q;
  assign o_abort          = abort_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_gfg_spi_slave_burst.sv
// Directed bench for gfg_spi_slave_burst: three instances (mode 0 RW=32, mode 3 RW=32,
// mode 0 RW=12) sharing the system clock, reset and MOSI, each with its own SCLK/SS.
`timescale 1ns/1ps
module tb_gfg_spi_slave_burst;

  localparam int HALF = 80;

  logic        sys_clk = 1'b0;
  logic        arst_n;
  logic        mosi;
  logic        sclk     [3];
  logic        ss_n     [3];
  logic        miso_w   [3];
  logic [4:0]  addr_w   [3];
  logic [4:0]  state_w  [3];
  logic        abort_w  [3];
  logic        we_w     [3];
  logic [31:0] wdata0, wdata3, rdata0, rdata3;
  logic [11:0] wdata12, rdata12;
  logic [31:0] regs0 [32];
  logic [31:0] regs3 [32];
  logic [11:0] regs12 [32];

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_q[$];
  int  we_cnt    [3];
  int  abort_cyc [3];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  gfg_spi_slave_burst #(.NUM_REGISTERS(32), .REGISTER_WIDTH(32), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
    .i_sys_clk(sys_clk), .i_arst_n(arst_n), .i_spi_clk(sclk[0]), .i_spi_mosi(mosi),
    .i_spi_ss_n(ss_n[0]), .o_spi_miso(miso_w[0]), .o_reg_addr(addr_w[0]),
    .o_reg_write_data(wdata0), .o_reg_write_en(we_w[0]), .i_reg_read_data(rdata0),
    .o_abort(abort_w[0]), .o_state(state_w[0]));

  gfg_spi_slave_burst #(.NUM_REGISTERS(32), .REGISTER_WIDTH(32), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut3 (
    .i_sys_clk(sys_clk), .i_arst_n(arst_n), .i_spi_clk(sclk[1]), .i_spi_mosi(mosi),
    .i_spi_ss_n(ss_n[1]), .o_spi_miso(miso_w[1]), .o_reg_addr(addr_w[1]),
    .o_reg_write_data(wdata3), .o_reg_write_en(we_w[1]), .i_reg_read_data(rdata3),
    .o_abort(abort_w[1]), .o_state(state_w[1]));

  gfg_spi_slave_burst #(.NUM_REGISTERS(32), .REGISTER_WIDTH(12), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut12 (
    .i_sys_clk(sys_clk), .i_arst_n(arst_n), .i_spi_clk(sclk[2]), .i_spi_mosi(mosi),
    .i_spi_ss_n(ss_n[2]), .o_spi_miso(miso_w[2]), .o_reg_addr(addr_w[2]),
    .o_reg_write_data(wdata12), .o_reg_write_en(we_w[2]), .i_reg_read_data(rdata12),
    .o_abort(abort_w[2]), .o_state(state_w[2]));

  // Register file model: read data follows the address with one cycle of latency.
  always @(posedge sys_clk) begin
    rdata0  <= regs0[addr_w[0]];
    rdata3  <= regs3[addr_w[1]];
    rdata12 <= regs12[addr_w[2]];
  end

  always @(negedge sys_clk) begin
    if (we_w[0] === 1'b1) wr_q.push_back({addr_w[0], wdata0});
    for (int i = 0; i < 3; i++) begin
      if (we_w[i] === 1'b1)    we_cnt[i]++;
      if (abort_w[i] === 1'b1) abort_cyc[i]++;
    end
  end

  function automatic bit cpol_of(input int idx);
    return (idx == 1);
  endfunction

  function automatic bit cpha_of(input int idx);
    return (idx == 1);
  endfunction

  task automatic ss_low(input int idx);
    ss_n[idx] = 1'b0;
    #(HALF);
  endtask

  task automatic ss_high(input int idx);
    #(HALF);
    ss_n[idx] = 1'b1;
    #(4*HALF);
  endtask

  // Master: n bits MSB-first from tx; MISO bits collected into rx.
  task automatic spi_xfer(input int idx, input logic [31:0] tx, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha_of(idx)) begin
        mosi = tx[i];
        #(HALF);
        rx = {rx[30:0], miso_w[idx]};
        sclk[idx] = ~cpol_of(idx);
        #(HALF);
        sclk[idx] = cpol_of(idx);
      end else begin
        sclk[idx] = ~cpol_of(idx);
        mosi = tx[i];
        #(HALF);
        rx = {rx[30:0], miso_w[idx]};
        sclk[idx] = cpol_of(idx);
        #(HALF);
      end
    end
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    #100;
    arst_n = 1'b1;
    #200;
    n_checks++;
    if (state_w[0] !== 5'b00001) $display("FAIL reset_state0 got=%b exp=00001", state_w[0]); else n_pass++;
    n_checks++;
    if (state_w[1] !== 5'b00001) $display("FAIL reset_state3 got=%b exp=00001", state_w[1]); else n_pass++;
    n_checks++;
    if ({miso_w[0], we_w[0], abort_w[0], addr_w[0]} !== 8'h00)
      $display("FAIL reset_outs0 got miso=%b we=%b abort=%b addr=%0d exp all 0", miso_w[0], we_w[0], abort_w[0], addr_w[0]);
    else n_pass++;
    n_checks++;
    if (wdata0 !== 32'h0) $display("FAIL reset_wdata0 got=%h exp=00000000", wdata0); else n_pass++;
    n_checks++;
    if (miso_w[1] !== 1'b0) $display("FAIL reset_miso3 got=%b exp=0", miso_w[1]); else n_pass++;
  endtask

  task automatic test_write_single;
    logic [31:0] rx;
    int base, ab;
    base = wr_q.size();
    ab   = abort_cyc[0];
    ss_low(0);
    spi_xfer(0, 32'h83, 8, rx);
    spi_xfer(0, 32'hDEADBEEF, 32, rx);
    ss_high(0);
    n_checks++;
    if (wr_q.size() - base !== 1) $display("FAIL wr1_count got=%0d exp=1", wr_q.size() - base); else n_pass++;
    if (wr_q.size() > base) begin
      n_checks++;
      if (wr_q[base].addr !== 5'd3) $display("FAIL wr1_addr got=%0d exp=3", wr_q[base].addr); else n_pass++;
      n_checks++;
      if (wr_q[base].data !== 32'hDEADBEEF) $display("FAIL wr1_data got=%h exp=deadbeef", wr_q[base].data); else n_pass++;
    end
    n_checks++;
    if (abort_cyc[0] - ab !== 0) $display("FAIL wr1_no_abort got=%0d exp=0", abort_cyc[0] - ab); else n_pass++;
    n_checks++;
    if (state_w[0] !== 5'b00001) $display("FAIL wr1_idle got=%b exp=00001", state_w[0]); else n_pass++;
  endtask

  task automatic test_read_mode3;
    logic [31:0] rx;
    int wc, ab;
    wc = we_cnt[1];
    ab = abort_cyc[1];
    regs3[5] = 32'h12345678;
    ss_low(1);
    spi_xfer(1, 32'h45, 8, rx);
    spi_xfer(1, 32'h0, 32, rx);
    ss_high(1);
    n_checks++;
    if (rx !== 32'h12345678) $display("FAIL rd3_data got=%h exp=12345678", rx); else n_pass++;
    n_checks++;
    if (we_cnt[1] - wc !== 0) $display("FAIL rd3_no_we got=%0d exp=0", we_cnt[1] - wc); else n_pass++;
    n_checks++;
    if (addr_w[1] !== 5'd5) $display("FAIL rd3_addr got=%0d exp=5", addr_w[1]); else n_pass++;
    n_checks++;
    if (abort_cyc[1] - ab !== 0) $display("FAIL rd3_no_abort got=%0d exp=0", abort_cyc[1] - ab); else n_pass++;
  endtask

  task automatic test_burst_write_wrap;
    logic [31:0] rx;
    logic [31:0] words [3];
    logic [4:0]  exp_addr [3];
    int base;
    words    = '{32'h11111111, 32'h22222222, 32'h33333333};
    exp_addr = '{5'd31, 5'd0, 5'd1};
    base = wr_q.size();
    ss_low(0);
    spi_xfer(0, 32'hBF, 8, rx);
    for (int w = 0; w < 3; w++) spi_xfer(0, words[w], 32, rx);
    ss_high(0);
    n_checks++;
    if (wr_q.size() - base !== 3) $display("FAIL burst_count got=%0d exp=3", wr_q.size() - base); else n_pass++;
    for (int w = 0; w < 3; w++) begin
      if (wr_q.size() > base + w) begin
        n_checks++;
        if (wr_q[base+w] !== {exp_addr[w], words[w]})
          $display("FAIL burst_word%0d got addr=%0d data=%h exp addr=%0d data=%h",
                   w, wr_q[base+w].addr, wr_q[base+w].data, exp_addr[w], words[w]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_burst_read_rw12;
    logic [31:0] rx;
    regs12[2] = 12'hABC;
    regs12[3] = 12'h123;
    ss_low(2);
    spi_xfer(2, 32'h42, 8, rx);
    for (int f = 0; f < 2; f++) begin
      spi_xfer(2, 32'h0, 16, rx);
      n_checks++;
      if (rx[15:0] !== 16'hABC0) $display("FAIL rd12_frame%0d got=%h exp=abc0", f, rx[15:0]); else n_pass++;
    end
    ss_high(2);
    n_checks++;
    if (addr_w[2] !== 5'd2) $display("FAIL rd12_addr got=%0d exp=2", addr_w[2]); else n_pass++;
    n_checks++;
    if (we_cnt[2] !== 0) $display("FAIL rd12_no_we got=%0d exp=0", we_cnt[2]); else n_pass++;
  endtask

  task automatic test_abort_mid_word;
    logic [31:0] rx;
    int base, ab;
    base = wr_q.size();
    ab   = abort_cyc[0];
    ss_low(0);
    spi_xfer(0, 32'h84, 8, rx);
    spi_xfer(0, 32'h1555, 13, rx);
    ss_high(0);
    n_checks++;
    if (abort_cyc[0] - ab !== 1) $display("FAIL abort_pulse got=%0d cycles exp=1", abort_cyc[0] - ab); else n_pass++;
    n_checks++;
    if (wr_q.size() - base !== 0) $display("FAIL abort_no_we got=%0d exp=0", wr_q.size() - base); else n_pass++;
    n_checks++;
    if (state_w[0] !== 5'b00001) $display("FAIL abort_idle got=%b exp=00001", state_w[0]); else n_pass++;
  endtask

  task automatic test_noop;
    logic [31:0] rx;
    int base, ab;
    base = wr_q.size();
    ab   = abort_cyc[0];
    ss_low(0);
    spi_xfer(0, 32'hC7, 8, rx);
    ss_high(0);
    n_checks++;
    if ((wr_q.size() - base !== 0) || (abort_cyc[0] - ab !== 0))
      $display("FAIL noop_quiet got writes=%0d aborts=%0d exp 0 0", wr_q.size() - base, abort_cyc[0] - ab);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] rx;
    regs3[7] = 32'hCAFEF00D;
    ss_low(1);
    spi_xfer(1, 32'h47, 8, rx);
    spi_xfer(1, 32'h0, 10, rx);
    arst_n = 1'b0;
    #30;
    n_checks++;
    if (miso_w[1] !== 1'b0) $display("FAIL arst_miso got=%b exp=0", miso_w[1]); else n_pass++;
    n_checks++;
    if (state_w[1] !== 5'b00001) $display("FAIL arst_state got=%b exp=00001", state_w[1]); else n_pass++;
    arst_n = 1'b1;
    #50;
    spi_xfer(1, 32'h0, 6, rx);
    n_checks++;
    if (state_w[1] !== 5'b00001) $display("FAIL arst_armed_off got=%b exp=00001", state_w[1]); else n_pass++;
    ss_high(1);
    ss_low(1);
    spi_xfer(1, 32'h47, 8, rx);
    spi_xfer(1, 32'h0, 32, rx);
    ss_high(1);
    n_checks++;
    if (rx !== 32'hCAFEF00D) $display("FAIL arst_next_frame got=%h exp=cafef00d", rx); else n_pass++;
  endtask

  initial begin
    mosi    = 1'b0;
    sclk[0] = 1'b0;
    sclk[1] = 1'b1;
    sclk[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ss_n[i]      = 1'b1;
      we_cnt[i]    = 0;
      abort_cyc[i] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      regs0[i]  = 32'h0;
      regs3[i]  = 32'h0;
      regs12[i] = 12'h0;
    end
    test_reset();
    test_write_single();
    test_read_mode3();
    test_burst_write_wrap();
    test_burst_read_rw12();
    test_abort_mid_word();
    test_noop();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
